// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   - Default widths for data and register address.
//   - Requester index constants (ALU = 0, load/multi-cycle unit = 1).
//   - Zero-register constant.
//   - Round-robin pick helper.
package regfile_wb_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam int ZERO_REG = 0;

  // Winner for a two-way round-robin: on a tie the requester that did not
  // win last time goes next, otherwise the only non-empty one wins.
  function automatic logic rr_pick(input logic ne0, input logic ne1,
                                   input logic rr_last);
    logic idx;
    idx = REQ_ALU;
    if (ne0 && ne1) begin
      idx = ~rr_last;
    end else if (ne1) begin
      idx = REQ_LSU;
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: small synchronous FIFO holding pending writeback entries.
// Ports:
//   clk, reset_n  - clock (rising edge), asynchronous active-low reset
//   push, din     - write an entry (caller guarantees !full)
//   pop, dout     - remove the head entry (caller guarantees !empty); dout
//                   always shows the current head
//   full, empty   - occupancy flags
// Pointers carry one extra MSB so that full and empty are distinguishable
// when the index bits are equal.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is data only; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// the ALU writeback (requester 0) and the load/multi-cycle unit
// (requester 1). Each requester feeds a wb_fifo; the FIFO heads arbitrate
// round-robin and the winner is issued through a registered write port.
// Ports:
//   clk, reset_n                  - clock, asynchronous active-low reset
//   reqN_valid/ready/addr/data    - requester N push interface (N = 0, 1)
//   RegWrite, write_addr,
//   write_data                    - registered register-file write port
//   idle                          - both FIFOs empty and no write in flight
// Optional feature, macro REGFILE_WB_FWD_EN:
//   fwd_rd_addr_k (in), fwd_hit_k / fwd_data_k (out), k = 1, 2 - bypass of
//   the write currently on the port, for readers in the same cycle.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = 2,
  parameter int DROP_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
`ifdef REGFILE_WB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_rd_addr_1,
  input  logic [ADDR_W-1:0] fwd_rd_addr_2,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
`endif
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              idle
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic               full0, empty0, push0, pop0;
  logic               full1, empty1, push1, pop1;
  logic [ENTRY_W-1:0] dout0, dout1;

  logic               gnt_vld;
  logic               gnt_idx;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               drop;

  logic               rr_last_q, rr_last_d;
  logic               reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]  write_addr_q, write_addr_d;
  logic [DATA_W-1:0]  write_data_q, write_data_d;

  // Ready depends only on the current occupancy, never on a same-cycle pop.
  assign req0_ready = !full0;
  assign req1_ready = !full1;
  assign push0      = req0_valid && !full0;
  assign push1      = req1_valid && !full1;

  wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo_alu (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push0),
    .pop    (pop0),
    .din    ({req0_addr, req0_data}),
    .dout   (dout0),
    .full   (full0),
    .empty  (empty0)
  );

  wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo_lsu (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push1),
    .pop    (pop1),
    .din    ({req1_addr, req1_data}),
    .dout   (dout1),
    .full   (full1),
    .empty  (empty1)
  );

  always_comb begin
    gnt_vld   = !empty0 || !empty1;
    gnt_idx   = rr_pick(!empty0, !empty1, rr_last_q);
    pop0      = gnt_vld && (gnt_idx == REQ_ALU);
    pop1      = gnt_vld && (gnt_idx == REQ_LSU);
    head_addr = (gnt_idx == REQ_LSU) ? dout1[DATA_W +: ADDR_W] : dout0[DATA_W +: ADDR_W];
    head_data = (gnt_idx == REQ_LSU) ? dout1[DATA_W-1:0] : dout0[DATA_W-1:0];
    // A register-0 head is still popped; it just never reaches the port.
    drop      = (DROP_ZERO != 0) && (head_addr == ADDR_W'(ZERO_REG));
  end

  always_comb begin
    rr_last_d    = gnt_vld ? gnt_idx : rr_last_q;
    reg_write_d  = gnt_vld && !drop;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (gnt_vld && !drop) begin
      write_addr_d = head_addr;
      write_data_d = head_data;
    end
  end

  // Output stage: registered write port and round-robin history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last_q    <= REQ_LSU;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      rr_last_q    <= rr_last_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWrite   = reg_write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign idle       = empty0 && empty1 && !reg_write_q;

`ifdef REGFILE_WB_FWD_EN
  logic zero_blk_1, zero_blk_2;

  // Register 0 is never forwarded when zero writes are being dropped.
  assign zero_blk_1 = (DROP_ZERO != 0) && (fwd_rd_addr_1 == ADDR_W'(ZERO_REG));
  assign zero_blk_2 = (DROP_ZERO != 0) && (fwd_rd_addr_2 == ADDR_W'(ZERO_REG));
  assign fwd_hit_1  = reg_write_q && (write_addr_q == fwd_rd_addr_1) && !zero_blk_1;
  assign fwd_hit_2  = reg_write_q && (write_addr_q == fwd_rd_addr_2) && !zero_blk_2;
  assign fwd_data_1 = fwd_hit_1 ? write_data_q : '0;
  assign fwd_data_2 = fwd_hit_2 ? write_data_q : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (default parameters).
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req0_valid, req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid, req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              idle;
`ifdef REGFILE_WB_FWD_EN
  logic [ADDR_W-1:0] fwd_rd_addr_1, fwd_rd_addr_2;
  logic              fwd_hit_1, fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_1, fwd_data_2;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [DATA_W-1:0] log_data[$];
  int                log_cyc[$];

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2), .DROP_ZERO(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
`ifdef REGFILE_WB_FWD_EN
    .fwd_rd_addr_1(fwd_rd_addr_1),
    .fwd_rd_addr_2(fwd_rd_addr_2),
    .fwd_hit_1    (fwd_hit_1),
    .fwd_hit_2    (fwd_hit_2),
    .fwd_data_1   (fwd_data_1),
    .fwd_data_2   (fwd_data_2),
`endif
    .RegWrite     (RegWrite),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Every cycle with RegWrite high is one register-file write.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      log_addr.push_back(write_addr);
      log_data.push_back(write_data);
      log_cyc.push_back(cyc_cnt);
    end
  end

  // A stalled request must be held stable until accepted.
  logic              st0_q = 1'b0, st1_q = 1'b0;
  logic [ADDR_W-1:0] sa0_q, sa1_q;
  logic [DATA_W-1:0] sd0_q, sd1_q;
  always @(posedge clk) begin
    if (reset_n === 1'b1 && st0_q)
      assert (req0_valid === 1'b1 && req0_addr === sa0_q && req0_data === sd0_q)
        else $error("FAIL req0_hold_stable data=%h held=%h", req0_data, sd0_q);
    if (reset_n === 1'b1 && st1_q)
      assert (req1_valid === 1'b1 && req1_addr === sa1_q && req1_data === sd1_q)
        else $error("FAIL req1_hold_stable data=%h held=%h", req1_data, sd1_q);
    st0_q <= (reset_n === 1'b1) && req0_valid && !req0_ready;
    st1_q <= (reset_n === 1'b1) && req1_valid && !req1_ready;
    sa0_q <= req0_addr; sd0_q <= req0_data;
    sa1_q <= req1_addr; sd1_q <= req1_data;
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_n = 1'b0;
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (idle !== 1'b1) begin
      failures++;
      $display("FAIL %s_idle_timeout idle=%b expected=1", name, idle);
    end
  endtask

  // Streams n0 entries on requester 0 and n1 on requester 1, data base+i,
  // holding each request until it is accepted.
  task automatic drive_streams(input int n0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] b0,
                               input int n1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] b1,
                               input string name, output bit saw_stall1);
    int i0, i1, n;
    bit f0, f1;
    i0 = 0; i1 = 0; n = 0; saw_stall1 = 1'b0;
    while ((i0 < n0 || i1 < n1) && n < 200) begin
      req0_valid = (i0 < n0); req0_addr = a0; req0_data = b0 + DATA_W'(i0);
      req1_valid = (i1 < n1); req1_addr = a1; req1_data = b1 + DATA_W'(i1);
      @(negedge clk);
      f0 = req0_valid && req0_ready;
      f1 = req1_valid && req1_ready;
      if (req1_valid && !req1_ready) saw_stall1 = 1'b1;
      @(posedge clk); #1;
      if (f0) i0++;
      if (f1) i1++;
      n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s_drive_timeout sent0=%0d sent1=%0d expected=%0d/%0d", name, i0, i1, n0, n1);
    end
  endtask

  task automatic test_reset();
    // Held in reset from time 0.
    #12;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL rst_regwrite got=%b exp=0", RegWrite); end
    checks++; if (write_addr !== '0) begin failures++; $display("FAIL rst_addr got=%h exp=0", write_addr); end
    checks++; if (write_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", write_data); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", idle); end
    #5 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rst_ready0 got=%b exp=1", req0_ready); end
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL rst_ready1 got=%b exp=1", req1_ready); end

    // Mid-stream reset with entries still queued.
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB1;
    @(posedge clk); #1;
    req0_data = 32'hA2; req1_data = 32'hB2;
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b1 || write_data !== 32'hA1) begin
      failures++; $display("FAIL midrst_pre_write got=%b/%h exp=1/000000a1", RegWrite, write_data);
    end
    #2 reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL midrst_regwrite got=%b exp=0", RegWrite); end
    checks++; if (write_addr !== '0) begin failures++; $display("FAIL midrst_addr got=%h exp=0", write_addr); end
    checks++; if (write_data !== '0) begin failures++; $display("FAIL midrst_data got=%h exp=0", write_data); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b exp=1", idle); end
    #2 reset_n = 1'b1;
    clear_log();
    repeat (6) @(posedge clk);
    #1;
    checks++; if (log_addr.size() != 0) begin failures++; $display("FAIL midrst_no_write got=%0d writes exp=0", log_addr.size()); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL midrst_idle_after got=%b exp=1", idle); end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    @(posedge clk); #1;  // accepted at this edge
    req0_valid = 1'b0;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL single_e1_regwrite got=%b exp=0", RegWrite); end
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b1) begin failures++; $display("FAIL single_regwrite got=%b exp=1", RegWrite); end
    checks++; if (write_addr !== 5'd5) begin failures++; $display("FAIL single_addr got=%h exp=05", write_addr); end
    checks++; if (write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", write_data); end
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL single_regwrite_drop got=%b exp=0", RegWrite); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (log_addr.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", log_addr.size()); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", idle); end
  endtask

  task automatic test_contention();
    bit st;
    logic [DATA_W-1:0] exp_d;
    logic [ADDR_W-1:0] exp_a;
    do_reset();
    drive_streams(6, 5'd1, 32'h100, 6, 5'd2, 32'h200, "contend", st);
    wait_idle("contend");
    checks++; if (log_data.size() != 12) begin failures++; $display("FAIL contend_count got=%0d exp=12", log_data.size()); end
    for (int i = 0; i < 12 && i < log_data.size(); i++) begin
      exp_d = ((i % 2) == 0) ? 32'h100 + DATA_W'(i / 2) : 32'h200 + DATA_W'(i / 2);
      exp_a = ((i % 2) == 0) ? 5'd1 : 5'd2;
      checks++;
      if (log_data[i] !== exp_d || log_addr[i] !== exp_a) begin
        failures++;
        $display("FAIL contend_order[%0d] got=%h@%0d exp=%h@%0d", i, log_data[i], log_addr[i], exp_d, exp_a);
      end
    end
    if (log_cyc.size() == 12) begin
      checks++;
      if (log_cyc[11] - log_cyc[0] != 11) begin
        failures++; $display("FAIL contend_no_gap span=%0d exp=11", log_cyc[11] - log_cyc[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit st;
    int c0, c1;
    do_reset();
    drive_streams(6, 5'd1, 32'h300, 4, 5'd2, 32'h400, "bp", st);
    wait_idle("bp");
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL bp_ready_drop saw_stall=%b exp=1", st); end
    c0 = 0; c1 = 0;
    for (int i = 0; i < log_data.size(); i++) begin
      if (log_addr[i] == 5'd1) begin
        checks++;
        if (log_data[i] !== 32'h300 + DATA_W'(c0)) begin failures++; $display("FAIL bp_req0_order[%0d] got=%h exp=%h", c0, log_data[i], 32'h300 + c0); end
        c0++;
      end else begin
        checks++;
        if (log_addr[i] !== 5'd2 || log_data[i] !== 32'h400 + DATA_W'(c1)) begin
          failures++; $display("FAIL bp_req1_order[%0d] got=%h@%0d exp=%h@2", c1, log_data[i], log_addr[i], 32'h400 + c1);
        end
        c1++;
      end
    end
    checks++; if (c0 != 6) begin failures++; $display("FAIL bp_req0_count got=%0d exp=6", c0); end
    checks++; if (c1 != 4) begin failures++; $display("FAIL bp_req1_count got=%0d exp=4", c1); end
  endtask

  task automatic test_zero_addr();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h11;
    @(posedge clk); #1;
    req0_addr = 5'd3; req0_data = 32'h33;
    @(posedge clk); #1;  // zero entry popped here without a write
    req0_valid = 1'b0;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL zero_dropped got=%b exp=0", RegWrite); end
    @(posedge clk); #1;
    checks++; if (RegWrite !== 1'b1 || write_addr !== 5'd3 || write_data !== 32'h33) begin
      failures++; $display("FAIL zero_next_write got=%b/%0d/%h exp=1/3/00000033", RegWrite, write_addr, write_data);
    end
    wait_idle("zero");
    checks++; if (log_addr.size() != 1) begin failures++; $display("FAIL zero_count got=%0d exp=1", log_addr.size()); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL zero_idle got=%b exp=1", idle); end
  endtask

`ifdef REGFILE_WB_FWD_EN
  task automatic test_forward();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h55;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    fwd_rd_addr_1 = 5'd7; fwd_rd_addr_2 = 5'd8;
    #1;
    checks++; if (fwd_hit_1 !== 1'b1) begin failures++; $display("FAIL fwd_hit1 got=%b exp=1", fwd_hit_1); end
    checks++; if (fwd_data_1 !== 32'h55) begin failures++; $display("FAIL fwd_data1 got=%h exp=00000055", fwd_data_1); end
    checks++; if (fwd_hit_2 !== 1'b0) begin failures++; $display("FAIL fwd_hit2 got=%b exp=0", fwd_hit_2); end
    checks++; if (fwd_data_2 !== 32'h0) begin failures++; $display("FAIL fwd_data2 got=%h exp=0", fwd_data_2); end
    @(posedge clk); #1;
    checks++; if (fwd_hit_1 !== 1'b0) begin failures++; $display("FAIL fwd_hit1_after got=%b exp=0", fwd_hit_1); end
    fwd_rd_addr_1 = '0; fwd_rd_addr_2 = '0;
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
`ifdef REGFILE_WB_FWD_EN
    fwd_rd_addr_1 = '0; fwd_rd_addr_2 = '0;
`endif
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_zero_addr();
`ifdef REGFILE_WB_FWD_EN
    test_forward();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
